// File: rtl/svc_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : svc_uart_rx                                                   |
// | Function : 8N1 UART receiver, glitch-filtered start detect, mid-bit      |
// |            sampling, 1-entry valid/ready holding register.               |
// |            Define SVC_UART_RX_PARITY_EN for an even-parity bit (8E1).    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module svc_uart_rx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       urx_valid,
    output logic [7:0] urx_data,
    input  logic       urx_ready,
    output logic       urx_frame_err,
    output logic       urx_overrun,
    output logic       urx_parity_err
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int c_tw         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_tw-1:0] c_full_bit = c_tw'(CLKS_PER_BIT - 1);
    localparam logic [c_tw-1:0] c_half_bit = c_tw'(CLKS_PER_BIT / 2 - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $fatal(1, "svc_uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef SVC_UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic [c_tw-1:0] r_timer;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_valid;
    logic [7:0]      r_data;
    logic            r_frame_err;
    logic            r_overrun;

    logic            w_tick;
    logic            w_load_half;
    logic            w_load_full;
    logic            w_shift_en;
    logic            w_commit;
    logic            w_frame_err;

`ifdef SVC_UART_RX_PARITY_EN
    logic            r_par;
    logic            r_parity_err;
    logic            w_par_sample;
    logic            w_parity_err;
    logic            w_par_ok;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign w_par_ok = ~(r_par ^ (^r_shift));
`endif

    assign w_tick = (r_timer == '0);

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_half  = 1'b0;
        w_load_full  = 1'b0;
        w_shift_en   = 1'b0;
        w_commit     = 1'b0;
        w_frame_err  = 1'b0;
`ifdef SVC_UART_RX_PARITY_EN
        w_par_sample = 1'b0;
        w_parity_err = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = S_START;
                    w_load_half  = 1'b1;
                end
            end
            S_START: begin
                // A start bit that is gone by mid-bit is a glitch, not a frame.
                if (w_tick) begin
                    if (!r_rx_s) begin
                        w_state_next = S_DATA;
                        w_load_full  = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_en  = 1'b1;
                    w_load_full = 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef SVC_UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef SVC_UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_par_sample = 1'b1;
                    w_load_full  = 1'b1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop lets a start bit right after stop be caught.
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_state_next = S_IDLE;
`ifdef SVC_UART_RX_PARITY_EN
                        if (w_par_ok) begin
                            w_commit = 1'b1;
                        end else begin
                            w_parity_err = 1'b1;
                        end
`else
                        w_commit = 1'b1;
`endif
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            if (w_load_half) begin
                r_timer <= c_half_bit;
            end else if (w_load_full) begin
                r_timer <= c_full_bit;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - 1'b1;
            end

            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
                r_idx   <= r_idx + 3'd1;
            end else if (r_state != S_DATA) begin
                r_idx   <= 3'd0;
            end
        end
    end

`ifdef SVC_UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_sample) begin
                r_par <= r_rx_s;
            end
            r_parity_err <= w_parity_err;
        end
    end

    assign urx_parity_err = r_parity_err;
`else
    assign urx_parity_err = 1'b0;
`endif

    // A commit into a full, non-accepting register drops the new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_data      <= 8'd0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
            if (w_commit) begin
                if (!r_valid || urx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && urx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign urx_valid     = r_valid;
    assign urx_data      = r_data;
    assign urx_frame_err = r_frame_err;
    assign urx_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_svc_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_svc_uart_rx                                                |
// | Function : Self-checking bench for svc_uart_rx at 10 clocks per bit.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_svc_uart_rx;

    localparam int CPB = 10;
`ifdef SVC_UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       urx_valid;
    logic [7:0] urx_data;
    logic       urx_ready;
    logic       urx_frame_err;
    logic       urx_overrun;
    logic       urx_parity_err;

    svc_uart_rx #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_rx        (uart_rx),
        .urx_valid      (urx_valid),
        .urx_data       (urx_data),
        .urx_ready      (urx_ready),
        .urx_frame_err  (urx_frame_err),
        .urx_overrun    (urx_overrun),
        .urx_parity_err (urx_parity_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Consumer-side observation: accepted bytes and pulse counts.
    logic [7:0] rx_buf [256];
    int n_rx = 0, rd = 0;
    int n_vc = 0, n_fe = 0, n_ov = 0, n_pe = 0;
    int vc0, fe0, ov0, pe0;
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (urx_valid && urx_ready && n_rx < 256) begin
                rx_buf[n_rx] = urx_data;
                n_rx = n_rx + 1;
            end
            if (urx_valid)      n_vc = n_vc + 1;
            if (urx_frame_err)  n_fe = n_fe + 1;
            if (urx_overrun)    n_ov = n_ov + 1;
            if (urx_parity_err) n_pe = n_pe + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        tick(CPB);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    task automatic snap();
        vc0 = n_vc; fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
    endtask

    task automatic drain(input string tag);
        int got;
        got = n_rx - rd;
        chk({tag, "_count"}, got, exp_q.size());
        for (int i = 0; i < got && i < exp_q.size(); i++)
            chk({tag, "_byte"}, rx_buf[rd + i], exp_q[i]);
        rd = n_rx;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       bad_stop, bad_par;
        int         fe_exp, pe_exp, n_good;

        rst = 1'b1; uart_rx = 1'b1; urx_ready = 1'b1;
        tick(3);
        chk("rst_valid", urx_valid, 1'b0);
        chk("rst_data",  urx_data,  8'h00);
        chk("rst_fe",    urx_frame_err, 1'b0);
        chk("rst_ov",    urx_overrun,   1'b0);
        chk("rst_pe",    urx_parity_err, 1'b0);
        rst = 1'b0;
        tick(5);

        // Single byte, consumer always ready.
        snap();
        send(8'hA5, 1'b1, ^8'hA5);
        tick(5);
        exp_q.push_back(8'hA5);
        drain("a5");
        chk("a5_valid_cycles", n_vc - vc0, 1);
        chk("a5_fe", n_fe - fe0, 0);
        chk("a5_ov", n_ov - ov0, 0);
        chk("a5_pe", n_pe - pe0, 0);

        // Back-to-back frames into a stalled consumer.
        urx_ready = 1'b0;
        snap();
        send(8'h3C, 1'b1, ^8'h3C);
        send(8'hC3, 1'b1, ^8'hC3);
        tick(3);
        chk("b2b_valid_held", urx_valid, 1'b1);
        chk("b2b_data_held",  urx_data,  8'h3C);
        chk("b2b_ov", n_ov - ov0, 1);
        chk("b2b_fe", n_fe - fe0, 0);
        urx_ready = 1'b1;
        tick(1);
        chk("b2b_valid_cleared", urx_valid, 1'b0);
        exp_q.push_back(8'h3C);
        drain("b2b");

        // Short low glitch on an idle line.
        snap();
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(20);
        chk("glitch_valid_cycles", n_vc - vc0, 0);
        chk("glitch_fe", n_fe - fe0, 0);
        chk("glitch_ov", n_ov - ov0, 0);
        drain("glitch");

        // Framing error followed by a held break, then a good byte.
        snap();
        send(8'h55, 1'b0, ^8'h55);
        uart_rx = 1'b0;
        tick(30);
        uart_rx = 1'b1;
        tick(15);
        chk("ferr_fe", n_fe - fe0, 1);
        chk("ferr_valid_cycles", n_vc - vc0, 0);
        send(8'h12, 1'b1, ^8'h12);
        tick(5);
        exp_q.push_back(8'h12);
        drain("ferr");
        chk("ferr_fe_after", n_fe - fe0, 1);

        // Reset in the middle of data bit 4 of 0xFF.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        uart_rx = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(2);
        chk("midrst_valid", urx_valid, 1'b0);
        chk("midrst_data",  urx_data,  8'h00);
        chk("midrst_fe",    urx_frame_err, 1'b0);
        chk("midrst_ov",    urx_overrun,   1'b0);
        chk("midrst_pe",    urx_parity_err, 1'b0);
        rst = 1'b0;
        tick(60);
        snap();
        send(8'h81, 1'b1, ^8'h81);
        tick(5);
        exp_q.push_back(8'h81);
        drain("midrst");
        chk("midrst_valid_cycles", n_vc - vc0, 1);

        if (PAR_EN) begin
            snap();
            send(8'h07, 1'b1, 1'b0);
            tick(5);
            chk("par_bad_pe", n_pe - pe0, 1);
            chk("par_bad_fe", n_fe - fe0, 0);
            drain("par_bad");
            send(8'h07, 1'b1, 1'b1);
            tick(5);
            exp_q.push_back(8'h07);
            drain("par_good");
            chk("par_good_pe", n_pe - pe0, 1);
            // Bad stop and bad parity together: only the framing error shows.
            snap();
            send(8'h07, 1'b0, 1'b0);
            uart_rx = 1'b1;
            tick(10);
            chk("par_prec_fe", n_fe - fe0, 1);
            chk("par_prec_pe", n_pe - pe0, 0);
            drain("par_prec");
        end else begin
            chk("nopar_pe_total", n_pe, 0);
        end

        // Randomized frames with random gaps, stop errors and parity errors.
        snap();
        fe_exp = 0; pe_exp = 0; n_good = 0;
        for (int f = 0; f < 16; f++) begin
            b        = 8'($urandom);
            bad_stop = ($urandom_range(0, 4) == 0);
            bad_par  = PAR_EN && ($urandom_range(0, 4) == 0);
            send(b, ~bad_stop, (^b) ^ bad_par);
            if (bad_stop) begin
                fe_exp++;
                uart_rx = 1'b0;
                tick($urandom_range(0, 8));
                uart_rx = 1'b1;
                tick($urandom_range(1, 6));
            end else begin
                if (bad_par) pe_exp++;
                else begin
                    exp_q.push_back(b);
                    n_good++;
                end
                tick($urandom_range(0, 6));
            end
        end
        uart_rx = 1'b1;
        tick(5);
        drain("rand");
        chk("rand_fe", n_fe - fe0, fe_exp);
        chk("rand_pe", n_pe - pe0, pe_exp);
        chk("rand_ov", n_ov - ov0, 0);
        chk("rand_valid_cycles", n_vc - vc0, n_good);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/svc_uart_rx.md
Name: svc_uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart to the codebase's UART transmitter.
- Synchronizes the asynchronous RX pin and detects start bits with a glitch filter.
- Samples each bit at its centre and delivers bytes over a valid/ready handshake through a 1-entry holding register.
- Sits between the board UART_RX pin and a consumer, such as a RISC-V MMIO peripheral or a debug loader.

Parameters:
- CLOCK_FREQ, 100_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- Derived localparam CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer divide). Elaboration fails if CLKS_PER_BIT < 4.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  serial line, asynchronous to clk; idles high.
- urx_valid  output  1  byte available in holding register.
- urx_data  output  8  received byte; stable while urx_valid=1.
- urx_ready  input  1  consumer accepts byte when urx_valid & urx_ready.
- urx_frame_err  output  1  1-cycle pulse: stop bit sampled 0.
- urx_overrun  output  1  1-cycle pulse: completed byte dropped because holding register full.
- urx_parity_err  output  1  1-cycle pulse: parity mismatch (see Optional Feature).

Behaviour:
- Reset state: FSM=IDLE, counters=0, sync flops=1, urx_valid=0, urx_data=0, all error pulses=0. Assertion mid-frame aborts immediately; no partial byte is ever delivered.
- Synchronizer: 2-flop on uart_rx, producing rx_s. All decisions use rx_s; the pin-to-decision latency is 2 clk.
- Bit timer: counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
- FSM states:
  - IDLE: on rx_s==0, go to START and load the timer for a half bit, (CLKS_PER_BIT/2)-1.
  - START: when the half-bit timer expires, resample. If rx_s==0, go to DATA with a full-bit timer and bit index 0. If rx_s==1, treat it as a glitch and return to IDLE with no error pulse.
  - DATA: at each full-bit expiry, shift rx_s into bit[idx], LSB first. After idx 7, go to STOP (or PARITY if the feature is enabled).
  - STOP: at mid-stop-bit expiry:
    - rx_s==1: commit the byte and go to IDLE.
    - rx_s==0: pulse urx_frame_err for 1 cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from retriggering frames.
- Commit timing: urx_valid rises the cycle after the mid-stop sample.
- Holding register and handshake:
  - urx_valid stays high until urx_valid & urx_ready, then clears next cycle unless a commit coincides with the accept.
  - Commit while urx_valid=1 and urx_ready=0: the new byte is dropped, the old byte is kept unchanged, and urx_overrun pulses 1 cycle.
  - Commit in the same cycle as an accept: load the new byte, urx_valid stays 1, no overrun.
  - urx_data changes only on a commit into an empty or accepting register.
- Back-to-back frames: returning to IDLE at mid-stop allows detection of a start bit that immediately follows the stop bit.
- Error pulses never coincide with a commit of the same frame.

Optional Feature:
- Macro: SVC_UART_RX_PARITY_EN.
- Defined: an even-parity bit is expected between bit 7 and stop, via an added PARITY state sampled at mid-bit. On mismatch with XOR(data), urx_parity_err pulses 1 cycle at the stop-bit sample and the byte is discarded. Framing is still checked; a framing error takes precedence, and only urx_frame_err pulses.
- Undefined: 8N1 only, with no PARITY state; urx_parity_err is tied to 0.

Test Plan (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10):
- Send 0xA5, urx_ready=1 -> urx_valid=1 for exactly 1 cycle with urx_data=0xA5; no error pulses.
- Send 0x3C then 0xC3 back-to-back (stop bit directly followed by start bit), urx_ready=0 until both are sent -> first 0x3C held; urx_overrun pulses once at the second commit; after accept, urx_valid=0.
- 3-cycle low glitch on idle line -> FSM returns to IDLE; urx_valid, urx_frame_err and urx_overrun all stay 0.
- Send 0x55 with stop bit forced 0, line held low for 30 cycles, then 0x12 -> urx_frame_err pulses once, nothing is delivered for 0x55, and 0x12 is then received correctly.
- Assert rst at data bit 4 of 0xFF, release, send 0x81 -> only 0x81 is delivered; all outputs read 0 during reset.
- With SVC_UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) -> urx_parity_err pulses and no byte is delivered. Send 0x07 with parity 1 -> byte is delivered.
